// File: rtl/ram_2port.sv
`default_nettype none
// ============================================================================
// Module      : ram_2port
// Description : Simple two-port RAM with one write port and one read port.
//               The write is synchronous. A read request is captured at the
//               edge where i_rd_en is high. The word is then moved into an
//               output register on the following edge, together with
//               o_rd_dv, so data comes out one cycle after the accepting edge.
// Ports       : i_rst      - asynchronous active-high reset (read valid pipe only)
//               i_wr_clk   - write port clock
//               i_wr_en    - write strobe
//               i_wr_addr  - write address
//               i_wr_data  - write data
//               i_rd_clk   - read port clock
//               i_rd_en    - read strobe
//               i_rd_addr  - read address
//               o_rd_data  - registered read data, qualified by o_rd_dv
//               o_rd_dv    - read data valid, one pulse per accepted read
// Revision    : 1.0 - initial release
// ============================================================================
module ram_2port #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                     i_rst,
    input  logic                     i_wr_clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_clk,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_rd_dv
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_word;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_pend;
    logic             r_rd_dv;

    always_ff @(posedge i_wr_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The array read and the output register hold no reset. Only the valid
    // pipeline is cleared, so the data is meaningful only while o_rd_dv is high.
    always_ff @(posedge i_rd_clk) begin
        if (i_rd_en) begin
            r_rd_word <= r_mem[i_rd_addr];
        end
        if (r_rd_pend) begin
            r_rd_data <= r_rd_word;
        end
    end

    always_ff @(posedge i_rd_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_pend <= 1'b0;
            r_rd_dv   <= 1'b0;
        end else begin
            r_rd_pend <= i_rd_en;
            r_rd_dv   <= r_rd_pend;
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_rd_dv   = r_rd_dv;

endmodule
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync
// Description : Single-clock FIFO controller driving a two-port RAM. It holds
//               the write and read pointers and the occupancy count. The
//               full, empty, almost-full and almost-empty flags are decoded
//               from the registered count. DEPTH must be a power of two and
//               at least 4, so that the pointers wrap naturally.
// Ports       : i_clk      - system clock, drives both RAM ports
//               i_rst      - asynchronous active-high reset
//               i_wr_dv    - push request, data on i_wr_data
//               i_wr_data  - push data
//               i_af_level - almost-full threshold, in free slots remaining
//               o_af_flag  - almost full
//               o_full     - FIFO full, pushes dropped
//               i_rd_en    - pop request
//               i_ae_level - almost-empty threshold, in words held
//               o_rd_dv    - o_rd_data valid
//               o_rd_data  - popped word
//               o_ae_flag  - almost empty
//               o_empty    - FIFO empty, pops ignored
//               o_count    - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_dv,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_af_level,
    output logic                     o_af_flag,
    output logic                     o_full,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_ae_level,
    output logic                     o_rd_dv,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_ae_flag,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    // The count is one bit wider than a pointer so that it can hold DEPTH.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] c_ONE   = CW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_af_thresh;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // Full blocks a write even when a read happens in the same cycle. Empty
    // blocks a read even when a write happens in the same cycle. The RAM has
    // no bypass path.
    assign w_push = i_wr_dv & ~w_full;
    assign w_pop  = i_rd_en & ~w_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // The levels are zero-extended to count width. An almost-full level of 0
    // makes the threshold DEPTH, so that the almost-full flag then matches full.
    assign w_af_thresh = c_DEPTH - {1'b0, i_af_level};

    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_af_flag = (r_count >= w_af_thresh);
    assign o_ae_flag = (r_count <= {1'b0, i_ae_level});
    assign o_count   = r_count;

    ram_2port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_rst     (i_rst),
        .i_wr_clk  (i_clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_wr_data),
        .i_rd_clk  (i_clk),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (o_rd_data),
        .o_rd_dv   (o_rd_dv)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync
// Description : Self-checking bench for fifo_sync (DEPTH=8, WIDTH=16,
//               af/ae levels of 2). A queue reference model tracks the
//               contents. Read data is expected one cycle after the edge
//               that accepts the pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int LVL   = 2;

    logic             clk;
    logic             rst;
    logic             i_wr_dv;
    logic [WIDTH-1:0] i_wr_data;
    logic [2:0]       i_af_level;
    logic             o_af_flag;
    logic             o_full;
    logic             i_rd_en;
    logic [2:0]       i_ae_level;
    logic             o_rd_dv;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_ae_flag;
    logic             o_empty;
    logic [3:0]       o_count;

    fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_dv    (i_wr_dv),
        .i_wr_data  (i_wr_data),
        .i_af_level (i_af_level),
        .o_af_flag  (o_af_flag),
        .o_full     (o_full),
        .i_rd_en    (i_rd_en),
        .i_ae_level (i_ae_level),
        .o_rd_dv    (o_rd_dv),
        .o_rd_data  (o_rd_data),
        .o_ae_flag  (o_ae_flag),
        .o_empty    (o_empty),
        .o_count    (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the words currently held, plus the read result that
    // one pop in flight will deliver.
    logic [WIDTH-1:0] q[$];
    bit               pend_dv;
    logic [WIDTH-1:0] pend_data;
    bit               exp_dv;
    logic [WIDTH-1:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(o_count), 32'(n));
        chk({tag, ".empty"}, 32'(o_empty), 32'(n == 0));
        chk({tag, ".full"},  32'(o_full),  32'(n == DEPTH));
        chk({tag, ".af"},    32'(o_af_flag), 32'(n >= DEPTH - LVL));
        chk({tag, ".ae"},    32'(o_ae_flag), 32'(n <= LVL));
        chk({tag, ".rd_dv"}, 32'(o_rd_dv), 32'(exp_dv));
        if (exp_dv) begin
            chk({tag, ".rd_data"}, 32'(o_rd_data), 32'(exp_data));
        end
    endtask

    // One clock: present the request, update the model, then check after the edge.
    task automatic cycle(input string tag, input logic wr, input logic [WIDTH-1:0] d, input logic rd);
        bit               acc_push;
        bit               acc_pop;
        logic [WIDTH-1:0] popped;
        popped   = '0;
        acc_push = wr && (q.size() < DEPTH);
        acc_pop  = rd && (q.size() != 0);
        if (acc_pop) popped = q.pop_front();
        if (acc_push) q.push_back(d);
        i_wr_dv   = wr;
        i_wr_data = d;
        i_rd_en   = rd;
        @(posedge clk);
        #1;
        exp_dv    = pend_dv;
        exp_data  = pend_data;
        pend_dv   = acc_pop;
        pend_data = popped;
        i_wr_dv   = 1'b0;
        i_rd_en   = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        rst        = 1'b1;
        i_wr_dv    = 1'b0;
        i_wr_data  = '0;
        i_rd_en    = 1'b0;
        i_af_level = 3'(LVL);
        i_ae_level = 3'(LVL);
        pend_dv    = 1'b0;
        pend_data  = '0;
        exp_dv     = 1'b0;
        exp_data   = '0;

        #12;
        check_outputs("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-stream: five words held and a read result about to appear.
        for (int i = 0; i < 6; i++) cycle("pre_rst_fill", 1'b1, 16'(16'h0050 + i), 1'b0);
        cycle("pre_rst_pop", 1'b0, '0, 1'b1);
        cycle("pre_rst_hold", 1'b0, '0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        pend_dv = 1'b0;
        exp_dv  = 1'b0;
        check_outputs("async_rst");
        #2;
        rst = 1'b0;
        cycle("pop_after_rst", 1'b0, '0, 1'b1);
        cycle("pop_after_rst_dv", 1'b0, '0, 1'b0);

        // Fill up to full, then one extra push that must be dropped.
        for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 16'(i), 1'b0);
        cycle("push_full", 1'b1, 16'hDEAD, 1'b0);

        // Drain back to back, then one extra pop that must be ignored.
        for (int i = 0; i < 9; i++) cycle("drain", 1'b0, '0, 1'b1);
        cycle("drain_tail", 1'b0, '0, 1'b0);
        cycle("drain_idle", 1'b0, '0, 1'b0);

        // Wrap the pointers around index 7 -> 0.
        for (int i = 0; i < 5; i++) cycle("wrap_push5", 1'b1, 16'(16'h0080 + i), 1'b0);
        for (int i = 0; i < 5; i++) cycle("wrap_pop5", 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle("wrap_push6", 1'b1, 16'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 6; i++) cycle("wrap_pop6", 1'b0, '0, 1'b1);
        cycle("wrap_tail", 1'b0, '0, 1'b0);

        // Simultaneous push and pop with three words held.
        for (int i = 0; i < 3; i++) cycle("sim3_fill", 1'b1, 16'(16'h0200 + i), 1'b0);
        cycle("sim3_both", 1'b1, 16'h0203, 1'b1);
        cycle("sim3_both2", 1'b1, 16'h0204, 1'b1);
        for (int i = 0; i < 4; i++) cycle("sim3_drain", 1'b0, '0, 1'b1);
        cycle("sim3_tail", 1'b0, '0, 1'b0);

        // Simultaneous push and pop while empty.
        cycle("sim_empty", 1'b1, 16'h0300, 1'b1);
        cycle("sim_empty_after", 1'b0, '0, 1'b0);
        cycle("sim_empty_pop", 1'b0, '0, 1'b1);
        cycle("sim_empty_tail", 1'b0, '0, 1'b0);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 8; i++) cycle("simf_fill", 1'b1, 16'(16'h0400 + i), 1'b0);
        cycle("sim_full", 1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < 7; i++) cycle("simf_drain", 1'b0, '0, 1'b1);
        cycle("simf_tail", 1'b0, '0, 1'b0);

        // Latency: push at edge N, pop at N+1, data valid after N+2.
        cycle("lat_push", 1'b1, 16'h00AA, 1'b0);
        cycle("lat_pop", 1'b0, '0, 1'b1);
        cycle("lat_data", 1'b0, '0, 1'b0);
        chk("lat_value", 32'(o_rd_data), 32'h00AA);

        // Randomised traffic against the queue model.
        for (int i = 0; i < 300; i++) begin
            cycle("random", 1'($urandom_range(0, 99) < 55), 16'($urandom), 1'($urandom_range(0, 99) < 50));
        end
        for (int i = 0; i < 9; i++) cycle("final_drain", 1'b0, '0, 1'b1);
        cycle("final_tail", 1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
Single-clock FIFO controller that drives the write and read ports of a two-port RAM.
- The RAM's write port is the FIFO's push side and its read port is the pop side.
- Generates pointers, occupancy count, full/empty status and programmable almost-full/almost-empty flags.
- Sits between a streaming producer and consumer in the same clock domain. It is the standard buffering block for later projects.

Parameters:
WIDTH, 16, data word width in bits
DEPTH, 256, number of entries; must be a power of two and at least 4

Ports:
i_clk  input  1  system clock; both RAM ports are clocked by it
i_rst  input  1  asynchronous reset, active-high
i_wr_dv  input  1  push request; data valid on i_wr_data
i_wr_data  input  WIDTH  push data
i_af_level  input  $clog2(DEPTH)  almost-full threshold, as free slots remaining
o_af_flag  output  1  almost full
o_full  output  1  FIFO full
i_rd_en  input  1  pop request
i_ae_level  input  $clog2(DEPTH)  almost-empty threshold, as words held
o_rd_dv  output  1  o_rd_data valid
o_rd_data  output  WIDTH  popped word
o_ae_flag  output  1  almost empty
o_empty  output  1  FIFO empty
o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values:
  - write pointer, read pointer and count = 0
  - o_rd_dv = 0, o_empty = 1, o_full = 0, o_ae_flag = 1, o_af_flag = 0, o_count = 0
  - o_rd_data is not reset; it is qualified only by o_rd_dv.
  - Reset mid-operation discards all contents immediately (asynchronous), with no drain.
- Push:
  - Accepted on a rising edge when i_wr_dv=1 and o_full=0.
  - RAM[wr_ptr] <= i_wr_data; wr_ptr increments.
  - A push while full is dropped silently: no pointer or count change, no error output.
- Pop:
  - Accepted when i_rd_en=1 and o_empty=0; RAM read issued at rd_ptr and rd_ptr increments.
  - o_rd_data and o_rd_dv=1 appear exactly 1 cycle later.
  - A pop while empty is ignored, and o_rd_dv=0 the next cycle.
  - o_rd_dv is high for one cycle per accepted pop. Back-to-back pops give continuous o_rd_dv.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous accepted push and pop.
- Simultaneous push and pop:
  - When empty: the push is accepted, the pop is ignored, and the count becomes 1.
  - When full: the pop is accepted, the push is dropped (full blocks the write regardless of the read), and the count becomes DEPTH-1.
  - Otherwise both are accepted.
- Write-to-read visibility: a word pushed at edge N can be popped at edge N+1 (o_empty deasserts after edge N). There is no same-cycle bypass.
- Flags are combinational from the registered count, so they update in the cycle after the causing edge:
  - o_full = (count == DEPTH)
  - o_empty = (count == 0)
  - o_af_flag = (count >= DEPTH - i_af_level)
  - o_ae_flag = (count <= i_ae_level)
- Width rules: count is $clog2(DEPTH)+1 bits so that it holds DEPTH. Threshold comparisons are done at count width with zero-extended levels.

Decomposition:
- No shared package needed. Address width and count width are local constants derived from DEPTH.
- One sub-module: instantiate the existing ram_2port with WIDTH and DEPTH passed through.
  - Both RAM clock inputs are tied to i_clk.
  - The RAM's write enable is the accepted-push strobe and its read enable is the accepted-pop strobe.
  - The RAM's read data and read valid drive o_rd_data and o_rd_dv.
- The FIFO itself holds only pointers, count and flag logic.

Test Plan:
Bench uses DEPTH=8, WIDTH=16, i_af_level=2, i_ae_level=2.
- Reset check: assert i_rst mid-stream with 5 words held -> immediately count=0, o_empty=1, o_ae_flag=1, o_rd_dv=0; the first pop after release is ignored.
- Fill: push 0x0001..0x0008 on consecutive cycles -> o_af_flag=1 once count reaches 6, o_full=1 at count 8. A 9th push of 0xDEAD is dropped and count stays 8.
- Drain: pop 8 times back-to-back -> o_rd_data = 0x0001..0x0008 in order, each 1 cycle after its pop. o_rd_dv is continuously high for 8 cycles, o_ae_flag=1 at count 2, o_empty=1 at count 0. A 9th pop gives o_rd_dv=0.
- Wrap: push 5, pop 5, then push 6 words 0x0100..0x0105 and pop 6 -> data is returned in order across the pointer wrap at index 7->0.
- Simultaneous ops:
  - push and pop together with count 3 -> count stays 3 and data order is preserved.
  - push and pop together while empty -> count becomes 1, no o_rd_dv.
  - push and pop together while full -> count becomes 7, the pushed word is lost, and the oldest word is returned.
- Latency: push 0x00AA at edge N, pop at edge N+1 -> o_rd_data=0x00AA with o_rd_dv=1 after edge N+2.
